// File: rtl/pc_sequencer_if.sv
// Fetch handshake, decode inputs and PC-select outputs shared between the
// sequencer and the surrounding datapath.
interface pc_sequencer_if;
    logic       fetch_req;
    logic       fetch_ack;
    logic       ir_load;
    logic       exec_en;
    logic       stall;
    logic [2:0] br_type;
    logic       zero;
    logic       cond_true;
    logic [1:0] PS;
    logic       halted;
    logic       fault;

    modport master (
        input  fetch_ack, stall, br_type, zero, cond_true,
        output fetch_req, ir_load, exec_en, PS, halted, fault
    );

    modport slave (
        output fetch_ack, stall, br_type, zero, cond_true,
        input  fetch_req, ir_load, exec_en, PS, halted, fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the PC function select (PS) once per instruction.
// Define PCSEQ_STATS_EN to add instr/taken/stall statistics counters.
//
// state   | meaning
// S_IDLE  | one quiet cycle after reset
// S_FETCH | fetch_req high, waiting for fetch_ack (bounded by TIMEOUT)
// S_EXEC  | resolve br_type/flags into PS; held while stall is high
// S_HALT  | halted, left only by reset
// S_FAULT | fetch timeout or reserved br_type, left only by reset
module pc_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    pc_sequencer_if.master    bus
`ifdef PCSEQ_STATS_EN
    ,
    output logic [CNT_W-1:0]  instr_count,
    output logic [CNT_W-1:0]  taken_count,
    output logic [CNT_W-1:0]  stall_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;

    logic       fetch_req_c, ir_load_c, exec_en_c, halted_c, fault_c;
    logic [1:0] ps_c;
    logic [1:0] ps_branch;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        ps_branch = 2'b01;
        case (bus.br_type)
            3'b001:  ps_branch = 2'b11;
            3'b010:  ps_branch = bus.zero      ? 2'b11 : 2'b01;
            3'b011:  ps_branch = bus.zero      ? 2'b01 : 2'b11;
            3'b100:  ps_branch = 2'b10;
            3'b101:  ps_branch = bus.cond_true ? 2'b11 : 2'b01;
            default: ps_branch = 2'b01;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        fetch_req_c  = 1'b0;
        ir_load_c    = 1'b0;
        exec_en_c    = 1'b0;
        halted_c     = 1'b0;
        fault_c      = 1'b0;
        ps_c         = 2'b00;

        case (state)
            S_IDLE: begin
                state_nxt    = S_FETCH;
                wait_cnt_nxt = '0;
            end
            S_FETCH: begin
                fetch_req_c = 1'b1;
                if (bus.fetch_ack) begin
                    ir_load_c    = 1'b1;
                    state_nxt    = S_EXEC;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt    = S_FAULT;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            S_EXEC: begin
                // A stall freezes the decision; flags are re-sampled when it drops.
                if (!bus.stall) begin
                    case (bus.br_type)
                        3'b110:  state_nxt = S_HALT;
                        3'b111:  state_nxt = S_FAULT;
                        default: begin
                            exec_en_c = 1'b1;
                            ps_c      = ps_branch;
                            state_nxt = S_FETCH;
                        end
                    endcase
                end
            end
            S_HALT:  halted_c = 1'b1;
            S_FAULT: fault_c  = 1'b1;
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are forced quiet during reset so the PC cannot move while it is held.
        if (reset) begin
            fetch_req_c = 1'b0;
            ir_load_c   = 1'b0;
            exec_en_c   = 1'b0;
            halted_c    = 1'b0;
            fault_c     = 1'b0;
            ps_c        = 2'b00;
        end
    end

    assign bus.fetch_req = fetch_req_c;
    assign bus.ir_load   = ir_load_c;
    assign bus.exec_en   = exec_en_c;
    assign bus.PS        = ps_c;
    assign bus.halted    = halted_c;
    assign bus.fault     = fault_c;

`ifdef PCSEQ_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            instr_count <= '0;
            taken_count <= '0;
            stall_count <= '0;
        end else begin
            if (exec_en_c)
                instr_count <= instr_count + CNT_W'(1);
            if (ps_c[1])
                taken_count <= taken_count + CNT_W'(1);
            if (state == S_EXEC && bus.stall)
                stall_count <= stall_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a cycle-level reference model.
module tb_pc_sequencer;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_EXEC  = 2;
    localparam int M_HALT  = 3;
    localparam int M_FAULT = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pc_sequencer_if bus ();

`ifdef PCSEQ_STATS_EN
    logic [CNT_W-1:0] instr_count, taken_count, stall_count;
`endif

    pc_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
`ifdef PCSEQ_STATS_EN
        ,
        .instr_count (instr_count),
        .taken_count (taken_count),
        .stall_count (stall_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    int mode    = M_IDLE;
    int waited  = 0;
    int m_instr = 0;
    int m_taken = 0;
    int m_stall = 0;

    logic [1:0] last_ps;
    logic       last_ir;
    logic [1:0] ps_log [7];
    logic       ir_log [7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ps_rule(input logic [2:0] br, input logic z, input logic c);
        bit taken;
        if (br == 3'd4) return 2'b10;
        taken = (br == 3'd1) || (br == 3'd2 && z) || (br == 3'd3 && !z) || (br == 3'd5 && c);
        return taken ? 2'b11 : 2'b01;
    endfunction

    task automatic step(input logic rst, input logic ack, input logic stl,
                        input logic [2:0] br, input logic z, input logic c);
        logic       e_fr, e_ir, e_en, e_h, e_f;
        logic [1:0] e_ps;
        @(negedge clock);
        reset         = rst;
        bus.fetch_ack = ack;
        bus.stall     = stl;
        bus.br_type   = br;
        bus.zero      = z;
        bus.cond_true = c;
        #1;
        e_fr = 0; e_ir = 0; e_en = 0; e_h = 0; e_f = 0; e_ps = 2'b00;
        if (!rst) begin
            if (mode == M_FETCH) begin
                e_fr = 1;
                e_ir = ack;
            end else if (mode == M_EXEC && !stl && br < 3'd6) begin
                e_en = 1;
                e_ps = ps_rule(br, z, c);
            end else if (mode == M_HALT) begin
                e_h = 1;
            end else if (mode == M_FAULT) begin
                e_f = 1;
            end
        end
        check("fetch_req", 32'(bus.fetch_req), 32'(e_fr));
        check("ir_load",   32'(bus.ir_load),   32'(e_ir));
        check("exec_en",   32'(bus.exec_en),   32'(e_en));
        check("PS",        32'(bus.PS),        32'(e_ps));
        check("halted",    32'(bus.halted),    32'(e_h));
        check("fault",     32'(bus.fault),     32'(e_f));
`ifdef PCSEQ_STATS_EN
        check("instr_count", instr_count, 32'(m_instr));
        check("taken_count", taken_count, 32'(m_taken));
        check("stall_count", stall_count, 32'(m_stall));
`endif
        last_ps = bus.PS;
        last_ir = bus.ir_load;
        @(posedge clock);
        if (rst) begin
            mode = M_IDLE; waited = 0;
            m_instr = 0; m_taken = 0; m_stall = 0;
        end else begin
            m_instr += int'(e_en);
            m_taken += int'(e_ps[1]);
            if (mode == M_EXEC && stl) m_stall++;
            case (mode)
                M_IDLE:  begin mode = M_FETCH; waited = 0; end
                M_FETCH: begin
                    if (ack) begin
                        mode = M_EXEC; waited = 0;
                    end else begin
                        waited++;
                        if (waited >= TIMEOUT) mode = M_FAULT;
                    end
                end
                M_EXEC: begin
                    if (!stl) begin
                        if (br == 3'd6)      mode = M_HALT;
                        else if (br == 3'd7) mode = M_FAULT;
                        else                 mode = M_FETCH;
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [1:0] exp_ps_seq [7];
        logic       exp_ir_seq [7];
        int         stuck;
        exp_ps_seq = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
        exp_ir_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        bus.fetch_ack = 0; bus.stall = 0; bus.br_type = 3'd0; bus.zero = 0; bus.cond_true = 0;

        step(1, 0, 0, 3'd0, 0, 0);
        step(1, 0, 0, 3'd0, 0, 0);

        // three plain instructions: IDLE, then FETCH/EXEC pairs
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 0, 3'd0, 0, 0);
            ps_log[i] = last_ps;
            ir_log[i] = last_ir;
        end
        for (int i = 0; i < 7; i++) begin
            check($sformatf("ps_seq[%0d]", i), 32'(ps_log[i]), 32'(exp_ps_seq[i]));
            check($sformatf("ir_seq[%0d]", i), 32'(ir_log[i]), 32'(exp_ir_seq[i]));
        end

        // branch resolution cases
        step(0, 1, 0, 3'd2, 1, 0); step(0, 0, 0, 3'd2, 1, 0);
        check("cbz_taken", 32'(last_ps), 32'(2'b11));
        step(0, 1, 0, 3'd2, 0, 0); step(0, 0, 0, 3'd2, 0, 0);
        check("cbz_not_taken", 32'(last_ps), 32'(2'b01));
        step(0, 1, 0, 3'd3, 0, 0); step(0, 0, 0, 3'd3, 0, 0);
        check("cbnz_taken", 32'(last_ps), 32'(2'b11));
        step(0, 1, 0, 3'd5, 0, 0); step(0, 0, 0, 3'd5, 0, 0);
        check("bcond_not_taken", 32'(last_ps), 32'(2'b01));
        step(0, 1, 0, 3'd4, 0, 0); step(0, 0, 0, 3'd4, 0, 0);
        check("br_load", 32'(last_ps), 32'(2'b10));

        // HALT sticks through fetch_ack toggling
        step(0, 1, 0, 3'd6, 0, 0); step(0, 0, 0, 3'd6, 0, 0);
        check("halt_ps", 32'(last_ps), 32'(2'b00));
        for (int i = 0; i < 20; i++) step(0, logic'(i % 2), 0, 3'(i % 8), 0, 0);
        check("halt_held", 32'(bus.halted), 32'(1));

        // fetch timeout
        step(1, 0, 0, 3'd0, 0, 0);
        step(0, 0, 0, 3'd0, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) step(0, 0, 0, 3'd0, 0, 0);
        step(0, 0, 0, 3'd0, 0, 0);
        check("timeout_fault", 32'(bus.fault), 32'(1));

        // stall over a taken branch
        step(1, 0, 0, 3'd0, 0, 0);
        step(0, 0, 0, 3'd0, 0, 0);
        step(0, 1, 0, 3'd1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 3'd1, 0, 0);
            check("stall_ps", 32'(last_ps), 32'(2'b00));
        end
        step(0, 0, 0, 3'd1, 0, 0);
        check("post_stall_ps", 32'(last_ps), 32'(2'b11));
`ifdef PCSEQ_STATS_EN
        #2;
        check("stall_count_3", stall_count, 32'd3);
        check("taken_count_1", taken_count, 32'd1);
`endif

        // reset in the middle of a fetch wait
        step(0, 0, 0, 3'd0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 3'd0, 0, 0);
        step(1, 0, 0, 3'd0, 0, 0);
        step(0, 0, 0, 3'd0, 0, 0);
        check("rst_mid_fetch_idle", 32'(last_ps), 32'(2'b00));
        for (int i = 0; i < TIMEOUT; i++) step(0, 0, 0, 3'd0, 0, 0);
        step(0, 0, 0, 3'd0, 0, 0);
        check("timeout_after_rst", 32'(bus.fault), 32'(1));

        // randomized traffic
        stuck = 0;
        for (int i = 0; i < 500; i++) begin
            int       r;
            logic     rst;
            logic [2:0] br;
            r   = int'($urandom_range(0, 31));
            br  = (r < 30) ? 3'(r % 6) : ((r == 30) ? 3'd6 : 3'd7);
            rst = ($urandom_range(0, 59) == 0) || (stuck > 4);
            stuck = (mode == M_HALT || mode == M_FAULT) ? stuck + 1 : 0;
            step(rst, logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 3) == 0),
                 br, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle controller that sequences the 64-bit program counter datapath.
- Drives the 2-bit PC function select (PS: 00 hold, 01 PC+4, 10 load, 11 PC+4+offset*4) once per instruction.
- Handshakes instruction fetch with instruction memory and resolves branch type and flags into a PS code.
- Sits between the decoder/flag logic and the PC register; the PC register loads every clock, so PS must be 00 in every cycle where the PC is to hold.

Parameters:
- TIMEOUT, 16, maximum cycles to wait for fetch_ack before entering FAULT (legal 2..255).
- CNT_W, 32, width of the optional statistics counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_ack  in  1  instruction memory has returned the instruction word this cycle.
- stall  in  1  hold in EXEC (hazard); PS forced to 00 while high.
- br_type  in  3  000 none, 001 B, 010 CBZ, 011 CBNZ, 100 BR, 101 B.cond, 110 HALT, 111 reserved.
- zero  in  1  register-zero flag for CBZ/CBNZ.
- cond_true  in  1  condition-code evaluation result for B.cond.
- fetch_req  out  1  request instruction at current PC.
- ir_load  out  1  load instruction register (one-cycle pulse).
- exec_en  out  1  datapath write enables permitted this cycle.
- PS  out  2  PC function select to the program counter.
- halted  out  1  sequencer in HALT.
- fault  out  1  sequencer in FAULT (fetch timeout or reserved br_type).

Behaviour:
- Reset: state=IDLE; all outputs 0; PS=00; timeout counter 0. Reset has priority over every other event, from any state, mid-fetch included.
- IDLE: one cycle with all outputs 0, then FETCH.
- FETCH: fetch_req=1, PS=00.
  - fetch_ack=1: ir_load=1 in the same cycle; next state EXEC; counter cleared.
  - fetch_ack=0: counter increments. When the counter reaches TIMEOUT-1 without an ack, next state is FAULT.
- EXEC, stall=1: exec_en=0, PS=00, stay in EXEC.
- EXEC, stall=0: exec_en=1 for exactly one cycle. PS is combinational from br_type/flags:
  - none → 01.
  - B → 11.
  - CBZ → 11 if zero else 01.
  - CBNZ → 11 if !zero else 01.
  - BR → 10.
  - B.cond → 11 if cond_true else 01.
  - Next state FETCH. The PC updates at the end of this cycle.
- EXEC, br_type=110 (HALT): PS=00, exec_en=0, next state HALT.
- EXEC, br_type=111: PS=00, exec_en=0, next state FAULT.
- HALT: halted=1, PS=00, fetch_req=0. Left only by reset.
- FAULT: fault=1, PS=00, fetch_req=0. Left only by reset.
- Latency: minimum 2 cycles per instruction (FETCH with immediate ack, then EXEC).
- PS is nonzero in at most one cycle per instruction, and only in EXEC with stall=0.
- fetch_ack outside FETCH is ignored.
- A stall arriving in the same cycle as a branch decision holds the PC; the decision is re-evaluated when stall drops, using the flags present in that cycle.
- halted and fault are mutually exclusive.

Optional Feature:
- Macro: PCSEQ_STATS_EN.
- Enabled adds three outputs, each CNT_W bits wide:
  - instr_count: increments on each EXEC cycle with exec_en=1.
  - taken_count: increments when PS is 10 or 11.
  - stall_count: increments on each EXEC cycle with stall=1.
- Counters wrap modulo 2^CNT_W and clear on reset.
- Disabled: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then fetch_ack=1 in each FETCH, br_type=000 for 3 instructions → PS sequence 00,00,01,00,01,00,01; ir_load pulses in cycles 2,4,6 (cycle 1 = IDLE, cycle 2 = first FETCH).
- CBZ with zero=1 → PS=11 for one cycle. CBZ with zero=0 → PS=01. CBNZ with zero=0 → 11. B.cond with cond_true=0 → 01.
- BR → PS=10 for one cycle. HALT → PS=00, halted=1 the next cycle, stays high for 20 cycles with fetch_ack toggling.
- fetch_ack held 0 with TIMEOUT=16 → fault=1 after 16 FETCH cycles, PS=00 throughout. Reset then recovers to IDLE.
- stall=1 for 3 cycles in EXEC with br_type=001 → PS=00 for 3 cycles, then PS=11 for one cycle. With PCSEQ_STATS_EN: stall_count=3, taken_count=1.
- Assert reset during a FETCH wait at count 5 → next cycle state IDLE, all outputs 0, counter 0.
